disp_scan_ctrl: RTL

//  Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
//  - Steps through the digits in turn.
//  - Drives the shared BCD bus and enable of the single downstream BCD-to-7-seg decoder.
//  - Drives one active-low anode line per digit.
//  - New display values arrive over a valid/ready handshake and are committed only
//    at frame boundaries, so a frame never shows half-old, half-new digits.

---
 rtl/disp_scan_if.sv | 28 ++
 rtl/disp_scan_ctrl.sv | 136 +++++++++++++
 2 files changed

// File: rtl/disp_scan_if.sv
// Handshake and display bus of disp_scan_ctrl: update source side (master)
// and the scan controller side (slave).
interface disp_scan_if #(
  parameter int NDIG = 4
);
  // Update transfer happens on any clock edge where upd_vld and upd_rdy are both 1;
  // the source holds upd_data/upd_vld while upd_rdy is 0, and upd_data only has to be
  // stable in the transfer cycle itself.
  logic [4*NDIG-1:0] upd_data;
  logic              upd_vld;
  logic              upd_rdy;
  logic              disp_en;
  logic [3:0]        bcd;
  logic              en;
  logic [NDIG-1:0]   an;
  logic              frame_tick;
  logic              showing;   // FSM state: 1 = SHOW, 0 = BLANK

  modport master (
    output upd_data, upd_vld, disp_en,
    input  upd_rdy, bcd, en, an, frame_tick, showing
  );

  modport slave (
    input  upd_data, upd_vld, disp_en,
    output upd_rdy, bcd, en, an, frame_tick, showing
  );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppresses leading zero digits).
module disp_scan_ctrl #(
  parameter int NDIG      = 4,
  parameter int PRESCALE  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst,
  disp_scan_if.slave  bus
);

  localparam int CMAX = (PRESCALE > BLANK_CYC) ? PRESCALE : BLANK_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int IW   = $clog2(NDIG);

  localparam logic [CW-1:0]   P_LAST   = CW'(PRESCALE - 1);
  localparam logic [CW-1:0]   B_LAST   = CW'(BLANK_CYC - 1);
  localparam logic [IW-1:0]   IDX_LAST = IW'(NDIG - 1);
  localparam logic [NDIG-1:0] AN_OFF   = '1;

  typedef enum logic {ST_BLANK = 1'b0, ST_SHOW = 1'b1} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] shown;
  logic [4*NDIG-1:0] staging;
  logic              pending;
  logic              upd_rdy_q;
  logic [3:0]        bcd_q;
  logic              en_q;
  logic [NDIG-1:0]   an_q;
  logic              frame_tick_q;

  logic              lz_blank;
  logic              show_on;
  logic [3:0]        bcd_show;
  logic [NDIG-1:0]   an_show;

`ifdef LEADING_ZERO_BLANK_EN
  // nz_from[k] is set when digit k or any digit above it is non-zero.
  logic [NDIG-1:0] nz_from;
  logic            nz_acc;

  always_comb begin
    nz_acc  = 1'b0;
    nz_from = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      nz_acc     = nz_acc | (|shown[4*k +: 4]);
      nz_from[k] = nz_acc;
    end
  end

  assign lz_blank = (idx != '0) && !nz_from[idx];
`else
  assign lz_blank = 1'b0;
`endif

  assign show_on  = bus.disp_en && !lz_blank;
  assign bcd_show = shown[4*idx +: 4];
  assign an_show  = show_on ? ~(NDIG'(1) << idx) : AN_OFF;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_BLANK;
      cnt          <= '0;
      idx          <= '0;
      shown        <= '0;
      staging      <= '0;
      pending      <= 1'b0;
      upd_rdy_q    <= 1'b1;
      bcd_q        <= '0;
      en_q         <= 1'b0;
      an_q         <= AN_OFF;
      frame_tick_q <= 1'b0;
    end else begin
      frame_tick_q <= 1'b0;
      case (state)
        ST_BLANK: begin
          if (cnt == B_LAST) begin
            state <= ST_SHOW;
            cnt   <= '0;
            bcd_q <= bcd_show;
            en_q  <= show_on;
            an_q  <= an_show;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_SHOW: begin
          if (cnt == P_LAST) begin
            state <= ST_BLANK;
            cnt   <= '0;
            bcd_q <= '0;
            en_q  <= 1'b0;
            an_q  <= AN_OFF;
            idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            // Frame end: the only point where a staged value may become visible.
            if (idx == IDX_LAST) begin
              frame_tick_q <= 1'b1;
              if (pending) begin
                shown     <= staging;
                pending   <= 1'b0;
                upd_rdy_q <= 1'b1;
              end
            end
          end else begin
            cnt   <= cnt + 1'b1;
            bcd_q <= bcd_show;
            en_q  <= show_on;
            an_q  <= an_show;
          end
        end
        default: begin
          state <= ST_BLANK;
          cnt   <= '0;
        end
      endcase
      // upd_rdy is 0 whenever pending is 1, so a transfer never collides with a commit.
      if (bus.upd_vld && upd_rdy_q) begin
        staging   <= bus.upd_data;
        pending   <= 1'b1;
        upd_rdy_q <= 1'b0;
      end
    end
  end

  assign bus.upd_rdy    = upd_rdy_q;
  assign bus.bcd        = bcd_q;
  assign bus.en         = en_q;
  assign bus.an         = an_q;
  assign bus.frame_tick = frame_tick_q;
  assign bus.showing    = (state == ST_SHOW);

endmodule
